// File: rtl/decoder_stream_pkg.sv
// Shared types for the streaming decoder: decode modes and FSM states.
package decoder_pkg;

    typedef enum logic [1:0] {
        DEC_ONEHOT,
        DEC_THERMO,
        DEC_INV,
        DEC_RSVD
    } dec_mode_t;

    typedef enum logic {
        DEC_IDLE,
        DEC_SCAN
    } dec_state_t;

endpackage

// File: rtl/decoder_stream_if.sv
// Request/response bundle for decoder_stream, plus the FSM state for observation.
interface decoder_stream_if
    import decoder_pkg::*;
#(
    parameter int N = 5
);
    localparam int OUT_W = 1 << N;

    // A beat transfers on any posedge where valid && ready; a producer holding
    // valid keeps its payload stable until that edge.
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in;
    logic             ena;
    dec_mode_t        mode;
    logic             scan_start;
    logic             scan_busy;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out;
    dec_state_t       dbg_state;

    modport master (
        output in_valid, in, ena, mode, scan_start, out_ready,
        input  in_ready, scan_busy, out_valid, out, dbg_state
    );

    modport slave (
        input  in_valid, in, ena, mode, scan_start, out_ready,
        output in_ready, scan_busy, out_valid, out, dbg_state
    );

endinterface

// File: rtl/decoder_stream_comb.sv
// Combinational N-to-2^N decoder with one-hot, thermometer and inverted modes.
module decoder_comb
    import decoder_pkg::*;
#(
    parameter int N = 5
) (
    input  logic [N-1:0]        sel,
    input  logic                ena,
    input  dec_mode_t           mode,
    output logic [(1<<N)-1:0]   word
);
    localparam int OUT_W = 1 << N;

    logic [OUT_W-1:0] onehot;
    logic [OUT_W-1:0] thermo;

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
        // Shifting out the top bit wraps to zero, so sel=OUT_W-1 yields all ones.
        thermo      = (onehot << 1) - OUT_W'(1);
    end

    always_comb begin
        word = '0;
        if (ena) begin
            case (mode)
                DEC_ONEHOT: word = onehot;
                DEC_THERMO: word = thermo;
                DEC_INV:    word = ~onehot;
                default:    word = '0;
            endcase
        end
    end

endmodule

// File: rtl/decoder_stream.sv
// Registered streaming decoder: request path, autonomous scan sweep, single output stage.
module decoder_stream
    import decoder_pkg::*;
#(
    parameter int N           = 5,
    parameter int SCAN_STRIDE = 1
) (
    input  logic            clk,
    input  logic            rst,
    decoder_stream_if.slave bus
);
    localparam int OUT_W = 1 << N;

    dec_state_t       state, state_n;
    logic [N:0]       cnt, cnt_n, cnt_sum;
    logic             slot_free;
    logic             load;
    logic             out_valid_q, out_valid_n;
    logic [OUT_W-1:0] out_q;
    logic [N-1:0]     dec_sel;
    logic             dec_ena;
    dec_mode_t        dec_mode;
    logic [OUT_W-1:0] dec_word;

    assign slot_free    = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !rst && (state == DEC_IDLE) && !bus.scan_start && slot_free;
    assign cnt_sum      = cnt + (N+1)'(SCAN_STRIDE);

    // The scan sweep reuses the request decoder, forced to a plain one-hot.
    always_comb begin
        dec_sel  = bus.in;
        dec_ena  = bus.ena;
        dec_mode = bus.mode;
        if (state == DEC_SCAN) begin
            dec_sel  = cnt[N-1:0];
            dec_ena  = 1'b1;
            dec_mode = DEC_ONEHOT;
        end
    end

    decoder_comb #(.N(N)) u_comb (
        .sel  (dec_sel),
        .ena  (dec_ena),
        .mode (dec_mode),
        .word (dec_word)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        load    = 1'b0;
        case (state)
            DEC_IDLE: begin
                if (bus.scan_start) begin
                    state_n = DEC_SCAN;
                    cnt_n   = '0;
                end else if (bus.in_valid && bus.in_ready) begin
                    load = 1'b1;
                end
            end
            DEC_SCAN: begin
                if (slot_free) begin
                    load  = 1'b1;
                    cnt_n = cnt_sum;
                    if (cnt_sum > (N+1)'(OUT_W - 1)) state_n = DEC_IDLE;
                end
            end
            default: state_n = DEC_IDLE;
        endcase
        out_valid_n = load ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= DEC_IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            out_valid_q <= out_valid_n;
            if (load) out_q <= dec_word;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.scan_busy = (state == DEC_SCAN);
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_decoder_stream.sv
// Self-checking bench for decoder_stream: N=5 stride 1, N=5 stride 3 and N=1 instances.
module tb_decoder_stream;
  import decoder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  decoder_stream_if #(.N(5)) bus_a();
  decoder_stream_if #(.N(5)) bus_b();
  decoder_stream_if #(.N(1)) bus_c();

  decoder_stream #(.N(5), .SCAN_STRIDE(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  decoder_stream #(.N(5), .SCAN_STRIDE(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));
  decoder_stream #(.N(1), .SCAN_STRIDE(1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c.slave));

  // Reference word from the mode rules, computed in 64-bit arithmetic then masked.
  function automatic logic [63:0] ref_word(int n, int sel, bit en, int md);
    logic [63:0] mask;
    logic [63:0] w;
    mask = (64'd1 << (1 << n)) - 64'd1;
    case (md)
      0:       w = 64'd1 << sel;
      1:       w = (64'd1 << (sel + 1)) - 64'd1;
      2:       w = ~(64'd1 << sel);
      default: w = 64'd0;
    endcase
    if (!en) w = 64'd0;
    return w & mask;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus_a.in_valid = 0; bus_a.in = '0; bus_a.ena = 0; bus_a.mode = DEC_ONEHOT;
    bus_a.scan_start = 0; bus_a.out_ready = 1;
    bus_b.in_valid = 0; bus_b.in = '0; bus_b.ena = 0; bus_b.mode = DEC_ONEHOT;
    bus_b.scan_start = 0; bus_b.out_ready = 1;
    bus_c.in_valid = 0; bus_c.in = '0; bus_c.ena = 0; bus_c.mode = DEC_ONEHOT;
    bus_c.scan_start = 0; bus_c.out_ready = 1;
  endtask

  task automatic test_reset();
    idle_all();
    bus_a.in_valid = 1; bus_a.ena = 1;
    rst = 1;
    tick(); tick();
    checks++; if (bus_a.out !== 32'h0) begin errors++; $display("FAIL reset_out: got %h want %h", bus_a.out, 32'h0); end
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus_a.out_valid); end
    checks++; if (bus_a.scan_busy !== 1'b0) begin errors++; $display("FAIL reset_scan_busy: got %b want 0", bus_a.scan_busy); end
    checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b want 0", bus_a.in_ready); end
    checks++; if (bus_a.dbg_state !== DEC_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", bus_a.dbg_state, DEC_IDLE); end
    checks++; if (bus_b.out_valid !== 1'b0) begin errors++; $display("FAIL reset_b_out_valid: got %b want 0", bus_b.out_valid); end
    checks++; if (bus_c.out !== 2'b00) begin errors++; $display("FAIL reset_c_out: got %b want 00", bus_c.out); end
    rst = 0;
    #1;
    checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %b want 1", bus_a.in_ready); end
    bus_a.in_valid = 0;
    tick();
  endtask

  task automatic test_random_sweep();
    logic [63:0] w;
    int md, sel;
    bit en;
    idle_all();
    for (int i = 0; i < 3000; i++) begin
      md  = $urandom_range(0, 3);
      sel = $urandom_range(0, 31);
      en  = 1'($urandom_range(0, 1));
      bus_a.in_valid = 1; bus_a.in = 5'(sel); bus_a.ena = en; bus_a.mode = dec_mode_t'(md);
      w = ref_word(5, sel, en, md);
      #1;
      checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL sweep_in_ready[%0d]: got %b want 1", i, bus_a.in_ready); end
      tick();
      checks++;
      if (bus_a.out_valid !== 1'b1 || bus_a.out !== w[31:0]) begin
        errors++;
        $display("FAIL sweep_word[%0d] mode=%0d in=%0d ena=%0d: got v=%b %h want v=1 %h", i, md, sel, en, bus_a.out_valid, bus_a.out, w[31:0]);
      end
    end
    bus_a.in_valid = 0;
    tick();
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL sweep_drain: got out_valid=%b want 0", bus_a.out_valid); end
  endtask

  task automatic test_stall();
    idle_all();
    bus_a.in_valid = 1; bus_a.in = 5'd4; bus_a.ena = 1; bus_a.mode = DEC_THERMO;
    tick();
    bus_a.in = 5'd9; bus_a.mode = DEC_ONEHOT; bus_a.out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (bus_a.out !== 32'h1F || bus_a.out_valid !== 1'b1 || bus_a.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got out=%h v=%b rdy=%b want out=0000001f v=1 rdy=0", k, bus_a.out, bus_a.out_valid, bus_a.in_ready);
      end
      tick();
    end
    bus_a.out_ready = 1;
    #1;
    checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", bus_a.in_ready); end
    tick();
    checks++;
    if (bus_a.out !== 32'h200 || bus_a.out_valid !== 1'b1) begin
      errors++; $display("FAIL stall_back_to_back: got out=%h v=%b want out=00000200 v=1", bus_a.out, bus_a.out_valid);
    end
    bus_a.in_valid = 0;
    tick();
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL stall_retire: got out_valid=%b want 0", bus_a.out_valid); end
  endtask

  task automatic test_scan_full();
    logic [63:0] w;
    logic [31:0] e;
    int busy_cnt;
    idle_all();
    exp_q.delete();
    for (int c = 0; c < 32; c++) begin
      w = ref_word(5, c, 1'b1, 0);
      exp_q.push_back(w[31:0]);
    end
    bus_a.scan_start = 1;
    tick();
    bus_a.scan_start = 0;
    busy_cnt = bus_a.scan_busy ? 1 : 0;
    checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL scan_entry_no_beat: got out_valid=%b want 0", bus_a.out_valid); end
    for (int k = 0; k < 32; k++) begin
      tick();
      e = exp_q.pop_front();
      if (bus_a.scan_busy) busy_cnt++;
      checks++;
      if (bus_a.out !== e || bus_a.out_valid !== 1'b1) begin
        errors++; $display("FAIL scan_beat[%0d]: got out=%h v=%b want out=%h v=1", k, bus_a.out, bus_a.out_valid, e);
      end
    end
    checks++; if (busy_cnt != 32) begin errors++; $display("FAIL scan_busy_cycles: got %0d want 32", busy_cnt); end
    tick();
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.dbg_state !== DEC_IDLE) begin
      errors++; $display("FAIL scan_end: got v=%b state=%0d want v=0 state=%0d", bus_a.out_valid, bus_a.dbg_state, DEC_IDLE);
    end
  endtask

  task automatic test_scan_stride3();
    logic [63:0] w;
    logic [31:0] e;
    int n_exp, got;
    idle_all();
    exp_q.delete();
    for (int c = 0; c < 32; c += 3) begin
      w = ref_word(5, c, 1'b1, 0);
      exp_q.push_back(w[31:0]);
    end
    n_exp = exp_q.size();
    got = 0;
    bus_b.scan_start = 1;
    tick();
    bus_b.scan_start = 0;
    for (int cyc = 0; cyc < 400 && exp_q.size() > 0; cyc++) begin
      bus_b.out_ready = 1'($urandom_range(0, 1));
      #1;
      if (bus_b.out_valid && bus_b.out_ready) begin
        e = exp_q.pop_front();
        got++;
        checks++;
        if (bus_b.out !== e) begin errors++; $display("FAIL stride3_beat[%0d]: got %h want %h", got - 1, bus_b.out, e); end
      end
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stride3_timeout: got %0d beats want %0d", got, n_exp); end
    bus_b.out_ready = 1;
    #1;
    checks++;
    if (bus_b.out_valid !== 1'b0 || bus_b.scan_busy !== 1'b0) begin
      errors++; $display("FAIL stride3_extra_beat: got v=%b busy=%b want v=0 busy=0", bus_b.out_valid, bus_b.scan_busy);
    end
  endtask

  task automatic test_collision_reset();
    idle_all();
    bus_a.in_valid = 1; bus_a.in = 5'd5; bus_a.ena = 1; bus_a.mode = DEC_THERMO;
    bus_a.scan_start = 1;
    #1;
    checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL collide_in_ready: got %b want 0", bus_a.in_ready); end
    tick();
    bus_a.scan_start = 0; bus_a.in_valid = 0;
    checks++;
    if (bus_a.out_valid !== 1'b0 || bus_a.scan_busy !== 1'b1) begin
      errors++; $display("FAIL collide_not_accepted: got v=%b busy=%b want v=0 busy=1", bus_a.out_valid, bus_a.scan_busy);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (bus_a.out !== (32'h1 << k)) begin errors++; $display("FAIL collide_beat[%0d]: got %h want %h", k, bus_a.out, 32'h1 << k); end
    end
    rst = 1;
    tick();
    checks++;
    if (bus_a.out !== 32'h0 || bus_a.out_valid !== 1'b0 || bus_a.scan_busy !== 1'b0 || bus_a.dbg_state !== DEC_IDLE) begin
      errors++;
      $display("FAIL midscan_reset: got out=%h v=%b busy=%b state=%0d want out=0 v=0 busy=0 state=0", bus_a.out, bus_a.out_valid, bus_a.scan_busy, bus_a.dbg_state);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_n1();
    logic [63:0] w;
    idle_all();
    for (int md = 0; md < 4; md++) begin
      for (int sel = 0; sel < 2; sel++) begin
        for (int en = 0; en < 2; en++) begin
          bus_c.in_valid = 1; bus_c.in = 1'(sel); bus_c.ena = 1'(en); bus_c.mode = dec_mode_t'(md);
          w = ref_word(1, sel, 1'(en), md);
          tick();
          checks++;
          if (bus_c.out_valid !== 1'b1 || bus_c.out !== w[1:0]) begin
            errors++;
            $display("FAIL n1_word mode=%0d in=%0d ena=%0d: got v=%b %b want v=1 %b", md, sel, en, bus_c.out_valid, bus_c.out, w[1:0]);
          end
        end
      end
    end
    bus_c.in_valid = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_random_sweep();
    test_stall();
    test_scan_full();
    test_scan_stride3();
    test_collision_reset();
    test_n1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
